// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-4 TDM demultiplexer.
package demux_pkg;

    localparam int unsigned LANES = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] lane_t;

    localparam lane_t LANE_O1 = 2'd0;
    localparam lane_t LANE_O2 = 2'd1;
    localparam lane_t LANE_O3 = 2'd2;
    localparam lane_t LANE_O4 = 2'd3;

    // Slot the counter returns to after a word lands in the last lane.
    localparam lane_t SLOT_WRAP = LANE_O1;

    // Slot that follows a transfer to lane cur.
    function automatic lane_t next_slot(input lane_t cur);
        if (cur == LANE_O4) begin
            return SLOT_WRAP;
        end
        return lane_t'(cur + lane_t'(1));
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: single-entry holding register with a valid flag.
module demux_lane #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ready
);

    // Lane can take a word when empty or being drained this cycle.
    assign ready = ~valid | rd_ready;

    // Write has priority over drain so a same-cycle drain+write keeps valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (wr_en) begin
            data  <= wr_data;
            valid <= 1'b1;
        end else if (rd_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_tdm_1to4.sv
// Registered 1-to-4 demultiplexer with direct (S) or TDM slot-counter lane select.
module demux_tdm_1to4
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic [SEL_W-1:0] S,
    input  logic             auto_en,
    input  logic             sync,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [WIDTH-1:0] O4,
    output logic [LANES-1:0] o_valid,
    input  logic [LANES-1:0] o_ready,
    output logic [SEL_W-1:0] slot,
    output logic             frame_done
);

    lane_t            lane_sel;
    logic             xfer;
    logic [LANES-1:0] lane_ready;
    logic [LANES-1:0] lane_wr;
    logic [WIDTH-1:0] lane_data [LANES];

    // Lane select: S in direct mode, slot counter (or O1 on sync) in auto mode.
    always_comb begin
        lane_sel = S;
        if (auto_en) begin
            lane_sel = sync ? LANE_O1 : slot;
        end
    end

    assign d_ready = lane_ready[lane_sel];
    assign xfer    = d_valid & d_ready;

    // Four identical holding lanes; only the selected one is written.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_wr[i] = xfer && (lane_sel == lane_t'(i));

        demux_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (lane_wr[i]),
            .wr_data  (D),
            .rd_ready (o_ready[i]),
            .data     (lane_data[i]),
            .valid    (o_valid[i]),
            .ready    (lane_ready[i])
        );
    end

    assign O1 = lane_data[LANE_O1];
    assign O2 = lane_data[LANE_O2];
    assign O3 = lane_data[LANE_O3];
    assign O4 = lane_data[LANE_O4];

    // Slot counter advances only on auto-mode transfers; frame_done flags an auto write to O4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= LANE_O1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= auto_en && xfer && (lane_sel == LANE_O4);
            if (auto_en) begin
                if (xfer) begin
                    slot <= next_slot(lane_sel);
                end else if (sync) begin
                    slot <= LANE_O1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_tdm_1to4.sv
// Directed scoreboard bench for demux_tdm_1to4.
module tb_demux_tdm_1to4;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic       d_valid;
    logic       d_ready;
    logic [1:0] S;
    logic       auto_en;
    logic       sync;
    logic [3:0] O1, O2, O3, O4;
    logic [3:0] o_valid;
    logic [3:0] o_ready;
    logic [1:0] slot;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] lane;
        logic [3:0] data;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    demux_tdm_1to4 #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .D          (D),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .S          (S),
        .auto_en    (auto_en),
        .sync       (sync),
        .O1         (O1),
        .O2         (O2),
        .O3         (O3),
        .O4         (O4),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .slot       (slot),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lane_o(input logic [1:0] l);
        case (l)
            2'd0:    return O1;
            2'd1:    return O2;
            2'd2:    return O3;
            default: return O4;
        endcase
    endfunction

    // Offer one word for one cycle; check d_ready, then the result one edge later.
    task automatic send(input logic [3:0] d, input logic [1:0] s, input logic ae,
                        input logic sy, input logic [3:0] ordy, input logic exp_rdy,
                        input logic [1:0] exp_lane, input logic exp_fd,
                        input logic [1:0] exp_slot);
        exp_t e;
        D = d; S = s; auto_en = ae; sync = sy; o_ready = ordy; d_valid = 1'b1;
        #1;
        chk("d_ready", 8'(d_ready), 8'(exp_rdy));
        if (exp_rdy) sb.push_back('{exp_lane, d, exp_fd});
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        sync    = 1'b0;
        chk("slot", 8'(slot), 8'(exp_slot));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("lane_data", 8'(lane_o(e.lane)), 8'(e.data));
            chk("lane_valid", 8'(o_valid[e.lane]), 8'd1);
            chk("frame_done", 8'(frame_done), 8'(e.fd));
        end else begin
            chk("frame_done_idle", 8'(frame_done), 8'd0);
        end
    endtask

    // One cycle with no word offered.
    task automatic idle(input logic ae, input logic sy, input logic [3:0] ordy);
        d_valid = 1'b0; auto_en = ae; sync = sy; o_ready = ordy;
        @(posedge clk);
        #1;
        sync = 1'b0;
    endtask

    initial begin
        rst = 1'b1; D = '0; d_valid = 1'b0; S = '0; auto_en = 1'b0; sync = 1'b0; o_ready = '0;
        #1;
        chk("rst_o1", 8'(O1), 8'd0);
        chk("rst_o4", 8'(O4), 8'd0);
        chk("rst_valid", 8'(o_valid), 8'd0);
        chk("rst_slot", 8'(slot), 8'd0);
        chk("rst_fd", 8'(frame_done), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 8'(d_ready), 8'd1);

        // Direct mode, all lanes draining.
        send(4'b0001, 2'b00, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd0);
        send(4'b0011, 2'b01, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b0, 2'd0);
        send(4'b0111, 2'b10, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 2'd0);
        send(4'b1111, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b0, 2'd0);
        idle(1'b0, 1'b0, 4'b1111);
        chk("direct_o1", 8'(O1), 8'b0001);
        chk("direct_o2", 8'(O2), 8'b0011);
        chk("direct_o3", 8'(O3), 8'b0111);
        chk("direct_o4", 8'(O4), 8'b1111);
        chk("drained", 8'(o_valid), 8'd0);

        // Auto mode deframing, S ignored.
        send(4'b0001, 2'b10, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd1);
        send(4'b0011, 2'b10, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b0, 2'd2);
        send(4'b0111, 2'b00, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 2'd3);
        send(4'b1111, 2'b00, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b1, 2'd0);
        send(4'b0001, 2'b11, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd1);
        idle(1'b1, 1'b1, 4'b1111);
        chk("sync_idle_slot", 8'(slot), 8'd0);
        chk("sync_idle_valid", 8'(o_valid), 8'd0);

        // Backpressure: lanes fill, fifth word stalls until O1 drains.
        send(4'b1000, 2'b00, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 2'd1);
        send(4'b1001, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd2);
        send(4'b1011, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 2'd3);
        send(4'b1100, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 2'd0);
        chk("bp_full", 8'(o_valid), 8'b1111);
        send(4'b0110, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("bp_o1_kept", 8'(O1), 8'b1000);
        send(4'b0110, 2'b00, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 2'd1);
        chk("bp_valid", 8'(o_valid), 8'b1111);
        idle(1'b0, 1'b0, 4'b1111);
        chk("bp_drained", 8'(o_valid), 8'd0);

        // Same-cycle drain and write on O2.
        send(4'b0101, 2'b01, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd1);
        send(4'b1010, 2'b01, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 2'd1);
        chk("dw_valid", 8'(o_valid), 8'b0010);

        // Mode switch mid-frame resumes at the held slot.
        send(4'b0001, 2'b00, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 2'd1);
        send(4'b0010, 2'b00, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd1, 1'b0, 2'd2);
        send(4'b1110, 2'b11, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd3, 1'b0, 2'd2);
        send(4'b0100, 2'b00, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd2, 1'b0, 2'd3);

        // Reset in the middle of traffic acts before any clock edge.
        send(4'b1101, 2'b00, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 2'd0);
        D = 4'b0011; d_valid = 1'b1; auto_en = 1'b1; o_ready = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_o1", 8'(O1), 8'd0);
        chk("mid_rst_o2", 8'(O2), 8'd0);
        chk("mid_rst_o3", 8'(O3), 8'd0);
        chk("mid_rst_o4", 8'(O4), 8'd0);
        chk("mid_rst_valid", 8'(o_valid), 8'd0);
        chk("mid_rst_slot", 8'(slot), 8'd0);
        chk("mid_rst_fd", 8'(frame_done), 8'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 8'(d_ready), 8'd1);
        d_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_valid", 8'(o_valid), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
